alu_iter: RTL and testbench

//  Parametrised, handshaked successor to the single-cycle integer ALU for the ARMv8 execute stage.
//  - Single-cycle ops (logic, add/sub, shifts, move): registered result, latency 1.
//  - Multiply: iterative shift-add over WIDTH cycles.
//  - NZCV flags: architecturally correct and registered; held, not cleared, when setflags=0.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_iter_if.sv | 28 ++
 rtl/alu_muldiv_iter.sv | 102 ++++++++++
 rtl/alu_iter.sv | 129 ++++++++++++
 tb/tb_alu_iter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op codes, NZCV bit positions and FSM encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ORR  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MUL  = 4'b0011;
    localparam logic [3:0] ALU_UDIV = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_MOV  = 4'b0111;
    localparam logic [3:0] ALU_EOR  = 4'b1000;
    localparam logic [3:0] ALU_ASR  = 4'b1001;
    localparam logic [3:0] ALU_LSR  = 4'b1010;
    localparam logic [3:0] ALU_LSL  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic [3:0] make_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/response bundle between the execute stage and alu_iter.
interface alu_iter_if #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic             setflags;
    logic [WIDTH-1:0] reg1_i;
    logic [WIDTH-1:0] reg2_i;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             busy;

    modport master (
        output in_valid, op, setflags, reg1_i, reg2_i, shamt, out_ready,
        input  in_ready, out_valid, result, flags, busy
    );

    modport slave (
        input  in_valid, op, setflags, reg1_i, reg2_i, shamt, out_ready,
        output in_ready, out_valid, result, flags, busy
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Shared shift-add multiplier / restoring divider, one bit per cycle for WIDTH cycles.
// The divider path is only built when ALU_ITER_DIV_EN is defined.
module alu_muldiv_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
`ifdef ALU_ITER_DIV_EN
    input  logic             is_div_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH);

    // mul: acc = partial product, a = shifted multiplicand, b = shifted multiplier
    // div: acc = remainder, a = dividend bits out / quotient bits in, b = divisor
    logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] step_acc, step_a, step_b;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
`ifdef ALU_ITER_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   rem_sh, diff;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        step_acc = acc_q + (b_q[0] ? a_q : '0);
        step_a   = a_q << 1;
        step_b   = b_q >> 1;
`ifdef ALU_ITER_DIV_EN
        rem_sh = {acc_q, a_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_q};
        if (div_q) begin
            step_acc = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            step_a   = {a_q[WIDTH-2:0], ~diff[WIDTH]};
            step_b   = b_q;
        end
`endif
    end

    always_comb begin
        acc_d = acc_q;
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        run_d = run_q;
`ifdef ALU_ITER_DIV_EN
        div_d = div_q;
`endif
        if (start_i) begin
            acc_d = '0;
            a_d   = a_i;
            b_d   = b_i;
            cnt_d = '0;
            run_d = 1'b1;
`ifdef ALU_ITER_DIV_EN
            div_d = is_div_i;
`endif
        end else if (run_q) begin
            acc_d = step_acc;
            a_d   = step_a;
            b_d   = step_b;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) run_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded by start_i before use.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        a_q   <= a_d;
        b_q   <= b_d;
`ifdef ALU_ITER_DIV_EN
        div_q <= div_d;
`endif
    end

    // The final step's value is exposed combinationally so the caller registers it on the DONE edge.
    assign done_o = run_q && (cnt_q == CW'(WIDTH - 1));
`ifdef ALU_ITER_DIV_EN
    assign result_o = div_q ? step_a : step_acc;
`else
    assign result_o = step_acc;
`endif

endmodule

// File: rtl/alu_iter.sv
// Handshaked ARMv8 execute-stage ALU: single-cycle logic/arith/shift ops, iterative MUL,
// and an iterative UDIV that is only built when ALU_ITER_DIV_EN is defined.
module alu_iter
    import alu_pkg::*;
#(
    parameter int         WIDTH      = 64,
    parameter int         SHW        = $clog2(WIDTH),
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input logic       clk,
    input logic       rst,
    alu_iter_if.slave bus
);
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             setflags_q, setflags_d;

    logic [WIDTH-1:0] a, b, b_eff, sum, sc_res, md_res;
    logic [SHW-1:0]   shamt;
    logic             accept, multi, sub, carry, sc_c, sc_v, md_start, md_done;

    assign a     = bus.reg1_i;
    assign b     = bus.reg2_i;
    assign shamt = bus.shamt;

    assign bus.in_ready = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    // UDIV by zero stays on the single-cycle path and returns 0.
`ifdef ALU_ITER_DIV_EN
    assign multi = (bus.op == ALU_MUL) | ((bus.op == ALU_UDIV) & (b != '0));
`else
    assign multi = (bus.op == ALU_MUL);
`endif
    assign md_start = accept & multi;

    // SUB is A + ~B + 1, so ADD and SUB share one adder and one overflow rule.
    assign sub            = (bus.op == ALU_SUB);
    assign b_eff          = sub ? ~b : b;
    assign {carry, sum}   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (bus.op)
            ALU_AND: sc_res = a & b;
            ALU_ORR: sc_res = a | b;
            ALU_EOR: sc_res = a ^ b;
            ALU_NOR: sc_res = ~(a | b);
            ALU_MOV: sc_res = b;
            ALU_ADD, ALU_SUB: begin
                sc_res = sum;
                sc_c   = carry;
                sc_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_LSL: sc_res = a << shamt;
            ALU_LSR: sc_res = a >> shamt;
            ALU_ASR: sc_res = $signed(a) >>> shamt;
            default: sc_res = '0;
        endcase
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
`ifdef ALU_ITER_DIV_EN
        .is_div_i (bus.op == ALU_UDIV),
`endif
        .a_i      (a),
        .b_i      (b),
        .done_o   (md_done),
        .result_o (md_res)
    );

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        flags_d    = flags_q;
        setflags_d = setflags_q;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && bus.out_ready) state_d = IDLE;
                if (accept) begin
                    setflags_d = bus.setflags;
                    if (multi) begin
                        state_d = BUSY;
                    end else begin
                        state_d  = DONE;
                        result_d = sc_res;
                        if (bus.setflags)
                            flags_d = make_flags(sc_res[WIDTH-1], sc_res == '0, sc_c, sc_v);
                    end
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_d  = DONE;
                    result_d = md_res;
                    if (setflags_q)
                        flags_d = make_flags(md_res[WIDTH-1], md_res == '0, 1'b0, 1'b0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            result_q   <= '0;
            flags_q    <= FLAG_RESET;
            setflags_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            setflags_q <= setflags_d;
        end
    end

    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == BUSY);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter (WIDTH=64): vector table through a scoreboard plus
// hand-written multi-cycle sequences (busy length, back-to-back, output stall, mid-MUL reset).
module tb_alu_iter;
    import alu_pkg::*;

    localparam int W = 64;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        sf;
        logic [63:0] a;
        logic [63:0] b;
        logic [5:0]  sh;
        logic [63:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] res;
        logic [3:0]  fl;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    logic [3:0] model_flags = 4'b0000;
    exp_t sb[$];
    vec_t vecs[$];

    alu_iter_if #(.WIDTH(W)) bus ();
    alu_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input string name, input logic [3:0] op, input logic sf,
                                    input logic [63:0] a, input logic [63:0] b, input logic [5:0] sh,
                                    input logic [63:0] res, input logic [3:0] fl, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.sf = sf; v.a = a; v.b = b; v.sh = sh;
        v.res = res; v.fl = fl; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Caller is at a negedge; returns #1 after the accepting edge with the expectation queued.
    task automatic issue(input vec_t v);
        exp_t e;
        int   t = 0;
        bus.in_valid = 1'b1;
        bus.op = v.op; bus.setflags = v.sf;
        bus.reg1_i = v.a; bus.reg2_i = v.b; bus.shamt = v.sh;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            check({"accept_timeout_", v.name}, 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (v.sf) model_flags = v.fl;
        e.name = v.name; e.res = v.res; e.fl = model_flags; e.lat = v.lat; e.acc_cyc = cyc;
        sb.push_back(e);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_scoreboard", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: latency from first out_valid, compare on transfer, stability while stalled.
    logic seen = 1'b0;
    int   first_cyc = 0;
    exp_t m;
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                first_cyc = cyc;
            end
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                m = sb[0];
                if (bus.out_ready) begin
                    check({m.name, "_result"}, bus.result, m.res);
                    check({m.name, "_flags"}, 64'(bus.flags), 64'(m.fl));
                    check({m.name, "_latency"}, 64'(first_cyc - m.acc_cyc + 1), 64'(m.lat));
                    void'(sb.pop_front());
                    seen = 1'b0;
                end else begin
                    check({m.name, "_hold_result"}, bus.result, m.res);
                    check({m.name, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
                end
            end
        end
    end

    initial begin
        vec_t v;
        int   bc, t, stray;

        bus.in_valid = 1'b0; bus.op = 4'd0; bus.setflags = 1'b0;
        bus.reg1_i = '0; bus.reg2_i = '0; bus.shamt = '0; bus.out_ready = 1'b1;

        add_vec("add_ovf",  ALU_ADD, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'h8000_0000_0000_0000, 4'b1001, 1);
        add_vec("sub_eq",   ALU_SUB, 1, 64'd5, 64'd5, 0, 64'd0, 4'b0110, 1);
        add_vec("and_nosf", ALU_AND, 0, 64'hF0F0, 64'hFF00, 0, 64'hF000, 4'b0000, 1);
        add_vec("orr",      ALU_ORR, 1, 64'hF0, 64'h0F, 0, 64'hFF, 4'b0000, 1);
        add_vec("eor",      ALU_EOR, 1, 64'hFF, 64'h0F, 0, 64'hF0, 4'b0000, 1);
        add_vec("nor",      ALU_NOR, 1, 64'd0, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1);
        add_vec("mov_zero", ALU_MOV, 1, 64'd9, 64'd0, 0, 64'd0, 4'b0100, 1);
        add_vec("add_wrap", ALU_ADD, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'd0, 4'b0110, 1);
        add_vec("add_negovf", ALU_ADD, 1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 64'd0, 4'b0111, 1);
        add_vec("sub_borrow", ALU_SUB, 1, 64'd3, 64'd5, 0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1);
        add_vec("sub_ovf",  ALU_SUB, 1, 64'h8000_0000_0000_0000, 64'd1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1);
        add_vec("lsl63",    ALU_LSL, 1, 64'd1, 64'd0, 63, 64'h8000_0000_0000_0000, 4'b1000, 1);
        add_vec("lsr63",    ALU_LSR, 1, 64'h8000_0000_0000_0000, 64'd0, 63, 64'd1, 4'b0000, 1);
        add_vec("asr4",     ALU_ASR, 1, 64'h8000_0000_0000_0000, 64'd0, 4, 64'hF800_0000_0000_0000, 4'b1000, 1);
        add_vec("asr0",     ALU_ASR, 1, 64'h4000_0000_0000_0000, 64'd0, 0, 64'h4000_0000_0000_0000, 4'b0000, 1);
        add_vec("lsl0",     ALU_LSL, 1, 64'h1234, 64'd0, 0, 64'h1234, 4'b0000, 1);
        add_vec("unknown",  4'b1111, 1, 64'd5, 64'd6, 0, 64'd0, 4'b0100, 1);
        add_vec("mul_ones", ALU_MUL, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd1, 4'b0000, 65);
        add_vec("mul_zero", ALU_MUL, 1, 64'd3, 64'd0, 0, 64'd0, 4'b0100, 65);
`ifdef ALU_ITER_DIV_EN
        add_vec("udiv",     ALU_UDIV, 1, 64'd100, 64'd7, 0, 64'd14, 4'b0000, 65);
`else
        add_vec("udiv",     ALU_UDIV, 1, 64'd100, 64'd7, 0, 64'd0, 4'b0100, 1);
`endif
        add_vec("udiv_by0", ALU_UDIV, 1, 64'd100, 64'd0, 0, 64'd0, 4'b0100, 1);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_flags", 64'(bus.flags), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Vector table, issued back to back
        foreach (vecs[i]) begin
            @(negedge clk);
            issue(vecs[i]);
        end
        drain();

        // MUL from the spec: busy length and 65-cycle latency
        v.name = "mul_spec"; v.op = ALU_MUL; v.sf = 1; v.a = 64'h1_0000_0003; v.b = 64'd7;
        v.sh = 0; v.res = 64'h7_0000_0015; v.fl = 4'b0000; v.lat = 65;
        @(negedge clk);
        issue(v);
        bc = 0; t = 0;
        do begin
            @(negedge clk);
            if (bus.busy) bc++;
            t++;
        end while (!bus.out_valid && t < 200);
        check("mul_busy_cycles", 64'(bc), 64'd64);
        drain();

        // Back-to-back issue while DONE & out_ready
        v.name = "b2b_first"; v.op = ALU_ADD; v.sf = 0; v.a = 64'd1; v.b = 64'd2; v.res = 64'd3; v.lat = 1;
        @(negedge clk);
        issue(v);
        @(negedge clk);
        check("b2b_valid_and_ready", {62'd0, bus.out_valid, bus.in_ready}, 64'd3);
        v.name = "b2b_second"; v.a = 64'd10; v.b = 64'd20; v.res = 64'd30;
        issue(v);
        check("b2b_no_bubble", 64'(bus.out_valid), 64'd1);
        drain();

        // Output stall for three cycles
        v.name = "stall_orr"; v.op = ALU_ORR; v.sf = 0; v.a = 64'hA0; v.b = 64'h0B; v.res = 64'hAB; v.lat = 1;
        @(negedge clk);
        issue(v);
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain();

        // Reset during MUL iteration 20
        v.name = "pre_rst_sub"; v.op = ALU_SUB; v.sf = 1; v.a = 64'd5; v.b = 64'd5; v.res = 64'd0;
        v.fl = 4'b0110; v.lat = 1;
        @(negedge clk);
        issue(v);
        drain();
        v.name = "mul_abandoned"; v.op = ALU_MUL; v.sf = 1; v.a = 64'd3; v.b = 64'd5; v.res = 64'd15;
        v.fl = 4'b0000; v.lat = 65;
        @(negedge clk);
        issue(v);
        repeat (20) @(posedge clk);
        #1;
        check("mul_busy_before_rst", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        sb.delete();
        model_flags = 4'b0000;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_flags", 64'(bus.flags), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        stray = 0;
        repeat (70) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        check("midrst_no_stray_valid", 64'(stray), 64'd0);
        v.name = "post_rst_orr"; v.op = ALU_ORR; v.sf = 1; v.a = 64'h8000_0000_0000_0000; v.b = 64'd1;
        v.res = 64'h8000_0000_0000_0001; v.fl = 4'b1000; v.lat = 1;
        @(negedge clk);
        issue(v);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
